evm_result_announcer: RTL and testbench

- Read-out end of the vote tally counters.
- On a START pulse, snapshots the six 10-bit tallies (P1..P5, NOTA) and runs a 6-cycle sequential scan.
- The scan determines the winner, a tie flag and the vote total.
- Then streams one record per contender over a valid/ready interface to the display/serial front end.

---
 rtl/evm_pkg.sv | 27 ++
 rtl/evm_result_announcer.sv | 147 ++++++++++++++
 tb/tb_evm_result_announcer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared constants and types for the EVM result read-out path.
// Record ids double as candidate numbers. ID_NONE marks "no winner".
package evm_pkg;

    localparam int DEFAULT_VOTE_W = 10;
    localparam int NUM_ENTRIES    = 6;

    localparam logic [2:0] ID_NONE = 3'd0;
    localparam logic [2:0] ID_P1   = 3'd1;
    localparam logic [2:0] ID_P2   = 3'd2;
    localparam logic [2:0] ID_P3   = 3'd3;
    localparam logic [2:0] ID_P4   = 3'd4;
    localparam logic [2:0] ID_P5   = 3'd5;
    localparam logic [2:0] ID_NOTA = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND
    } state_t;

    // Snapshot slot index 0..5 maps onto record id 1..6.
    function automatic logic [2:0] entry_to_id(input logic [2:0] entry);
        return entry + 3'd1;
    endfunction

endpackage

// File: rtl/evm_result_announcer.sv
// Snapshots the six vote tallies, scans them one per cycle for winner/tie/total,
// then streams one (id, count) record per contender over valid/ready.
module evm_result_announcer
    import evm_pkg::*;
#(
    parameter int VOTE_W  = DEFAULT_VOTE_W,
    parameter int TOTAL_W = 13
) (
    input  logic               CLK,
    input  logic               CLEAR,
    input  logic               START,
    input  logic [VOTE_W-1:0]  P1_VOTES,
    input  logic [VOTE_W-1:0]  P2_VOTES,
    input  logic [VOTE_W-1:0]  P3_VOTES,
    input  logic [VOTE_W-1:0]  P4_VOTES,
    input  logic [VOTE_W-1:0]  P5_VOTES,
    input  logic [VOTE_W-1:0]  NOTA_VOTES,
    input  logic               OUT_READY,
    output logic               OUT_VALID,
    output logic [2:0]         OUT_ID,
    output logic [VOTE_W-1:0]  OUT_COUNT,
    output logic               OUT_LAST,
    output logic [2:0]         WINNER_ID,
    output logic               TIE,
    output logic [TOTAL_W-1:0] TOTAL_VOTES,
    output logic               RESULT_VALID,
    output logic               BUSY
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_ENTRIES - 1);

    state_t              state;
    logic [2:0]          idx;
    logic [VOTE_W-1:0]   snap [NUM_ENTRIES];
    logic [VOTE_W-1:0]   max_val;
    logic [2:0]          win_acc;
    logic                tie_acc;
    logic [TOTAL_W-1:0]  total_acc;

    logic [VOTE_W-1:0]   cur;
    logic [TOTAL_W-1:0]  total_next;
    logic                beat_done;

    assign cur        = snap[idx];
    assign total_next = total_acc + {{(TOTAL_W - VOTE_W){1'b0}}, cur};
    assign beat_done  = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state        <= IDLE;
            idx          <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                snap[i] <= '0;
            end
            max_val      <= '0;
            win_acc      <= ID_NONE;
            tie_acc      <= 1'b0;
            total_acc    <= '0;
            OUT_VALID    <= 1'b0;
            OUT_ID       <= ID_NONE;
            OUT_COUNT    <= '0;
            OUT_LAST     <= 1'b0;
            WINNER_ID    <= ID_NONE;
            TIE          <= 1'b0;
            TOTAL_VOTES  <= '0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        snap[0]      <= P1_VOTES;
                        snap[1]      <= P2_VOTES;
                        snap[2]      <= P3_VOTES;
                        snap[3]      <= P4_VOTES;
                        snap[4]      <= P5_VOTES;
                        snap[5]      <= NOTA_VOTES;
                        idx          <= '0;
                        max_val      <= '0;
                        win_acc      <= ID_NONE;
                        tie_acc      <= 1'b0;
                        total_acc    <= '0;
                        WINNER_ID    <= ID_NONE;
                        TIE          <= 1'b0;
                        TOTAL_VOTES  <= '0;
                        RESULT_VALID <= 1'b0;
                        BUSY         <= 1'b1;
                        state        <= SCAN;
                    end
                end

                SCAN: begin
                    total_acc <= total_next;
                    // Strict '>' keeps the earlier (lower) id on equal counts; NOTA never contends.
                    if (idx != LAST_IDX) begin
                        if (cur > max_val) begin
                            max_val <= cur;
                            win_acc <= entry_to_id(idx);
                            tie_acc <= 1'b0;
                        end else if ((cur == max_val) && (cur != '0)) begin
                            tie_acc <= 1'b1;
                        end
                    end

                    if (idx == LAST_IDX) begin
                        WINNER_ID    <= win_acc;
                        TIE          <= tie_acc;
                        TOTAL_VOTES  <= total_next;
                        RESULT_VALID <= 1'b1;
                        OUT_VALID    <= 1'b1;
                        OUT_ID       <= ID_P1;
                        OUT_COUNT    <= snap[0];
                        OUT_LAST     <= 1'b0;
                        idx          <= '0;
                        state        <= SEND;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end

                SEND: begin
                    if (beat_done) begin
                        if (OUT_LAST) begin
                            OUT_VALID <= 1'b0;
                            OUT_LAST  <= 1'b0;
                            OUT_ID    <= ID_NONE;
                            OUT_COUNT <= '0;
                            idx       <= '0;
                            BUSY      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            OUT_ID    <= entry_to_id(idx + 3'd1);
                            OUT_COUNT <= snap[idx + 3'd1];
                            OUT_LAST  <= (entry_to_id(idx + 3'd1) == ID_NOTA);
                            idx       <= idx + 3'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evm_result_announcer.sv
// Self-checking bench for evm_result_announcer: directed cases plus randomized
// tallies and READY patterns, checked against an arithmetic reference model.
module tb_evm_result_announcer;
    import evm_pkg::*;

    localparam int VW = 10;
    localparam int TW = 13;

    logic          CLK = 1'b0;
    logic          CLEAR;
    logic          START;
    logic [VW-1:0] P1_VOTES, P2_VOTES, P3_VOTES, P4_VOTES, P5_VOTES, NOTA_VOTES;
    logic          OUT_READY;
    logic          OUT_VALID;
    logic [2:0]    OUT_ID;
    logic [VW-1:0] OUT_COUNT;
    logic          OUT_LAST;
    logic [2:0]    WINNER_ID;
    logic          TIE;
    logic [TW-1:0] TOTAL_VOTES;
    logic          RESULT_VALID;
    logic          BUSY;

    int nCompared   = 0;
    int nMismatched = 0;
    int tally [6];

    always #5 CLK = ~CLK;

    evm_result_announcer #(.VOTE_W(VW), .TOTAL_W(TW)) dut (
        .CLK          (CLK),
        .CLEAR        (CLEAR),
        .START        (START),
        .P1_VOTES     (P1_VOTES),
        .P2_VOTES     (P2_VOTES),
        .P3_VOTES     (P3_VOTES),
        .P4_VOTES     (P4_VOTES),
        .P5_VOTES     (P5_VOTES),
        .NOTA_VOTES   (NOTA_VOTES),
        .OUT_READY    (OUT_READY),
        .OUT_VALID    (OUT_VALID),
        .OUT_ID       (OUT_ID),
        .OUT_COUNT    (OUT_COUNT),
        .OUT_LAST     (OUT_LAST),
        .WINNER_ID    (WINNER_ID),
        .TIE          (TIE),
        .TOTAL_VOTES  (TOTAL_VOTES),
        .RESULT_VALID (RESULT_VALID),
        .BUSY         (BUSY)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus();
        P1_VOTES   = VW'(tally[0]);
        P2_VOTES   = VW'(tally[1]);
        P3_VOTES   = VW'(tally[2]);
        P4_VOTES   = VW'(tally[3]);
        P5_VOTES   = VW'(tally[4]);
        NOTA_VOTES = VW'(tally[5]);
    endtask

    // Reference: highest candidate count wins, lowest id among equals; zero max means nobody.
    task automatic modelResult(output int expW, output int expT, output int expTot);
        int mx;
        int cnt;
        mx = 0;
        cnt = 0;
        expW = 0;
        expTot = 0;
        for (int i = 0; i < 6; i++) expTot += tally[i];
        for (int i = 0; i < 5; i++) if (tally[i] > mx) mx = tally[i];
        if (mx > 0) begin
            for (int i = 4; i >= 0; i--) begin
                if (tally[i] == mx) begin
                    expW = i + 1;
                    cnt++;
                end
            end
        end
        expT = (cnt > 1) ? 1 : 0;
    endtask

    // readyMode: 0 = READY high, 1 = stall 3 cycles on id 2, 2 = random READY
    task automatic runReadout(input int readyMode, input bit busyStarts, input bit changeP3);
        int expW, expT, expTot;
        int edges;
        int guard;
        int stall;
        bit ready;
        bit sentSendStart;
        int qid[$];
        int qcnt[$];

        modelResult(expW, expT, expTot);
        for (int i = 0; i < 6; i++) begin
            qid.push_back(i + 1);
            qcnt.push_back(tally[i]);
        end
        applyStimulus();
        OUT_READY = (readyMode == 0);
        START = 1'b1;
        tick();
        START = 1'b0;
        edges = 1;
        checkOutput("busy_after_start", 32'(BUSY), 32'd1);
        checkOutput("rv_cleared_on_start", 32'(RESULT_VALID), 32'd0);
        if (changeP3) P3_VOTES = VW'(99);

        while (!OUT_VALID && edges < 20) begin
            if (busyStarts && edges == 2) START = 1'b1;
            tick();
            START = 1'b0;
            edges++;
        end
        checkOutput("scan_latency", 32'(edges), 32'd7);
        checkOutput("result_valid", 32'(RESULT_VALID), 32'd1);
        checkOutput("winner_id", 32'(WINNER_ID), 32'(expW));
        checkOutput("tie", 32'(TIE), 32'(expT));
        checkOutput("total_votes", 32'(TOTAL_VOTES), 32'(expTot));

        guard = 0;
        stall = 0;
        sentSendStart = 1'b0;
        while (qid.size() > 0 && guard < 200) begin
            checkOutput("out_valid", 32'(OUT_VALID), 32'd1);
            checkOutput("out_id", 32'(OUT_ID), 32'(qid[0]));
            checkOutput("out_count", 32'(OUT_COUNT), 32'(qcnt[0]));
            checkOutput("out_last", 32'(OUT_LAST), (qid[0] == 6) ? 32'd1 : 32'd0);
            case (readyMode)
                0: ready = 1'b1;
                1: begin
                    ready = !(qid[0] == 2 && stall < 3);
                    if (!ready) stall++;
                end
                default: ready = 1'($urandom_range(0, 1));
            endcase
            OUT_READY = ready;
            if (busyStarts && !sentSendStart) begin
                START = 1'b1;
                sentSendStart = 1'b1;
            end
            tick();
            START = 1'b0;
            edges++;
            guard++;
            if (ready) begin
                void'(qid.pop_front());
                void'(qcnt.pop_front());
            end
        end
        OUT_READY = 1'b0;
        checkOutput("beats_left", 32'(qid.size()), 32'd0);
        checkOutput("valid_after_last", 32'(OUT_VALID), 32'd0);
        checkOutput("busy_after_last", 32'(BUSY), 32'd0);
        checkOutput("result_held", 32'(RESULT_VALID), 32'd1);
        checkOutput("winner_held", 32'(WINNER_ID), 32'(expW));
        if (readyMode == 0) checkOutput("readout_cycles", 32'(edges), 32'd13);
    endtask

    initial begin
        CLEAR = 1'b1;
        START = 1'b0;
        OUT_READY = 1'b0;
        for (int i = 0; i < 6; i++) tally[i] = 0;
        applyStimulus();
        tick();
        tick();
        CLEAR = 1'b0;
        checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_result_valid", 32'(RESULT_VALID), 32'd0);
        checkOutput("rst_winner", 32'(WINNER_ID), 32'd0);
        checkOutput("rst_total", 32'(TOTAL_VOTES), 32'd0);
        checkOutput("rst_out_id", 32'(OUT_ID), 32'd0);

        tally = '{5, 12, 3, 9, 0, 20};
        runReadout(0, 1'b0, 1'b0);
        checkOutput("tp_nontie_winner", 32'(WINNER_ID), 32'd2);
        checkOutput("tp_nontie_total", 32'(TOTAL_VOTES), 32'd49);

        tally = '{8, 8, 1, 0, 0, 0};
        runReadout(0, 1'b0, 1'b0);
        checkOutput("tp_tie_winner", 32'(WINNER_ID), 32'd1);
        checkOutput("tp_tie_flag", 32'(TIE), 32'd1);
        checkOutput("tp_tie_total", 32'(TOTAL_VOTES), 32'd17);

        tally = '{0, 0, 0, 0, 0, 0};
        runReadout(0, 1'b0, 1'b0);
        checkOutput("tp_zero_winner", 32'(WINNER_ID), 32'd0);
        checkOutput("tp_zero_tie", 32'(TIE), 32'd0);

        tally = '{4, 7, 3, 2, 6, 1};
        runReadout(1, 1'b0, 1'b1);

        // Abort a read-out while beat 3 is waiting.
        tally = '{11, 22, 33, 44, 55, 66};
        applyStimulus();
        OUT_READY = 1'b1;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 0; n < 30 && !(OUT_VALID && OUT_ID == 3'd3); n++) tick();
        checkOutput("clr_reached_beat3", 32'(OUT_ID), 32'd3);
        OUT_READY = 1'b0;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        checkOutput("clr_out_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("clr_busy", 32'(BUSY), 32'd0);
        checkOutput("clr_result_valid", 32'(RESULT_VALID), 32'd0);
        checkOutput("clr_winner", 32'(WINNER_ID), 32'd0);
        checkOutput("clr_total", 32'(TOTAL_VOTES), 32'd0);
        checkOutput("clr_out_count", 32'(OUT_COUNT), 32'd0);
        tick();
        checkOutput("clr_stays_idle", 32'(BUSY), 32'd0);
        runReadout(0, 1'b0, 1'b0);

        tally = '{1023, 1023, 1023, 1023, 1023, 1023};
        runReadout(0, 1'b1, 1'b0);
        checkOutput("tp_max_total", 32'(TOTAL_VOTES), 32'd6138);
        checkOutput("tp_max_winner", 32'(WINNER_ID), 32'd1);
        checkOutput("tp_max_tie", 32'(TIE), 32'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("busy_start_not_queued", 32'(BUSY), 32'd0);
            checkOutput("no_extra_beat", 32'(OUT_VALID), 32'd0);
        end

        for (int iter = 0; iter < 20; iter++) begin
            for (int i = 0; i < 6; i++) begin
                tally[i] = (iter % 2 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 4));
            end
            runReadout(2, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
